// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencer.
//  - seq_state_e : sequencer FSM state encoding
//  - MAC_N       : default operand/result width
//  - MAC_LEN_W   : default command length field width
package mac_pkg;

  localparam int MAC_N     = 16;
  localparam int MAC_LEN_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ZERO,
    S_LOAD,
    S_FLUSH,
    S_CAPT
  } seq_state_e;

endpackage

// File: rtl/mac_seq.sv
// mac_seq: drives a signed MAC through one dot product per command.
//  For each command it streams cmd_len (a,b) pairs into the MAC with sload low,
//  runs one flush cycle so the last product lands in the accumulator, then
//  captures the MAC P bus into an output register presented with valid/ready.
//
// Ports
//  clk, arst_n            clock, asynchronous active-low reset
//  cmd_valid/ready/len    command handshake and pair count
//  s_valid/ready, s_a/b   operand pair stream (signed)
//  m_valid/ready, m_data  result handshake and signed result (MAC P verbatim)
//  m_err                  result came from a stalled, aborted command
//  mac_ce, mac_sload      MAC clock enable / extract-and-clear select
//  mac_a, mac_b           MAC operands
//  mac_pvalid, mac_p      MAC result valid and P bus (high-Z when not valid)
//
// Configuration
//  MAC_SEQ_TIMEOUT_EN : when defined, TO_CYC consecutive idle operand cycles in
//                       LOAD abort the command; the partial sum is delivered
//                       with m_err=1. Undefined: LOAD waits forever, m_err=0.
module mac_seq
  import mac_pkg::*;
#(
  parameter int N      = MAC_N,
  parameter int LEN_W  = MAC_LEN_W,
  parameter int TO_CYC = 15
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [N-1:0]     s_a,
  input  logic [N-1:0]     s_b,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [N-1:0]     m_data,
  output logic             m_err,
  output logic             mac_ce,
  output logic             mac_sload,
  output logic [N-1:0]     mac_a,
  output logic [N-1:0]     mac_b,
  input  logic             mac_pvalid,
  input  logic [N-1:0]     mac_p
);

  if (TO_CYC < 1) begin : g_bad_to_cyc
    $error("mac_seq: TO_CYC must be at least 1");
  end

  seq_state_e       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             m_valid_q, m_valid_d;
  logic [N-1:0]     m_data_q, m_data_d;
  logic             m_err_q, m_err_d;

  logic             timeout;  // LOAD gave up waiting for operands
  logic             abort;    // current command ended by timeout
  logic             out_free; // output register may take a new result

  assign out_free = !m_valid_q || m_ready;

`ifdef MAC_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC + 1);

  logic [TW-1:0] stall_q, stall_d;
  logic          err_q, err_d;

  // Fires on the TO_CYC-th consecutive idle cycle; any beat clears the count.
  assign timeout = (state_q == S_LOAD) && !s_valid && (stall_q == TW'(TO_CYC - 1));
  assign abort   = err_q;

  always_comb begin
    stall_d = '0;
    if (state_q == S_LOAD && !s_valid) stall_d = stall_q + TW'(1);
    err_d = err_q;
    if (state_q == S_IDLE) err_d = 1'b0;
    if (timeout)           err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end
`else
  assign timeout = 1'b0;
  assign abort   = 1'b0;
`endif

  // State and result registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_err_q   <= m_err_d;
    end
  end

  // Next state. A handshake drops m_valid unless a capture on the same edge
  // refills the register, in which case the new result wins.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    m_valid_d = m_valid_q && !m_ready;
    m_data_d  = m_data_q;
    m_err_d   = m_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cnt_d   = cmd_len;
          state_d = (cmd_len == '0) ? S_ZERO : S_LOAD;
        end
      end
      S_ZERO: begin
        if (out_free) begin
          m_data_d  = '0;
          m_valid_d = 1'b1;
          m_err_d   = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_LOAD: begin
        if (s_valid) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = S_FLUSH;
        end else if (timeout) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: state_d = S_CAPT;
      S_CAPT: begin
        // P is only trusted while the MAC flags it valid.
        if (out_free && mac_pvalid) begin
          m_data_d  = mac_p;
          m_valid_d = 1'b1;
          m_err_d   = abort;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // MAC control. Outside LOAD the MAC idles in extract mode with zero
  // operands so the accumulator's upper half stays cleared between bursts.
  always_comb begin
    cmd_ready = 1'b0;
    s_ready   = 1'b0;
    mac_ce    = 1'b1;
    mac_sload = 1'b1;
    mac_a     = '0;
    mac_b     = '0;
    unique case (state_q)
      S_IDLE: cmd_ready = 1'b1;
      S_LOAD: begin
        s_ready   = 1'b1;
        mac_sload = 1'b0;
        mac_ce    = s_valid;  // a missing operand freezes the whole MAC pipe
        mac_a     = s_a;
        mac_b     = s_b;
      end
      S_CAPT: mac_ce = out_free;  // hold P while the consumer backpressures
      default: ;
    endcase
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_err   = m_err_q;

endmodule

// File: tb/tb_mac_seq.sv
`timescale 1ns/1ps
module tb_mac_seq;

  localparam int N     = 16;
  localparam int LEN_W = 8;
`ifdef MAC_SEQ_TIMEOUT_EN
  localparam int TO    = 4;
`else
  localparam int TO    = 15;
`endif

  logic             clk = 1'b0;
  logic             arst_n;
  logic             cmd_valid, cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             s_valid, s_ready;
  logic [N-1:0]     s_a, s_b;
  logic             m_valid, m_ready;
  logic [N-1:0]     m_data;
  logic             m_err;
  logic             mac_ce, mac_sload;
  logic [N-1:0]     mac_a, mac_b;
  logic             mac_pvalid;
  wire  [N-1:0]     mac_p;

  always #5 clk = ~clk;

  mac_seq #(.N(N), .LEN_W(LEN_W), .TO_CYC(TO)) dut (
    .clk(clk), .arst_n(arst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_err(m_err),
    .mac_ce(mac_ce), .mac_sload(mac_sload), .mac_a(mac_a), .mac_b(mac_b),
    .mac_pvalid(mac_pvalid), .mac_p(mac_p)
  );

  // Signed MAC: registered product, accumulator, registered sload.
  // sload_r=1 clears only the accumulator's upper half on the next add.
  logic [2*N-1:0] acc, prod;
  logic           sl;
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      acc <= '0; prod <= '0; sl <= 1'b1;
    end else if (mac_ce) begin
      sl   <= mac_sload;
      prod <= $signed(mac_a) * $signed(mac_b);
      acc  <= (sl ? {{N{1'b0}}, acc[N-1:0]} : acc) + prod;
    end
  end
  assign mac_pvalid = sl;
  assign mac_p      = sl ? acc[2*N-1:N] : 'z;

  // ---------------- checking ----------------
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Result = upper half of (residual low half + sum of signed products) mod 2^2N.
  logic [N-1:0] qa[$], qb[$];
  logic [N-1:0] exp_d[$];
  logic         exp_e[$];
  logic [N-1:0] resid;

  task automatic model_push(input logic err);
    logic [2*N-1:0] t;
    longint p;
    t = {{N{1'b0}}, resid};
    foreach (qa[i]) begin
      p = longint'($signed(qa[i])) * longint'($signed(qb[i]));
      t = t + (2*N)'(p);
    end
    exp_d.push_back(t[2*N-1:N]);
    exp_e.push_back(err);
    resid = t[N-1:0];
  endtask

  // Result scoreboard: a handshake happens at the next posedge.
  always @(negedge clk) begin
    if (arst_n && m_valid && m_ready) begin
      chk("result_expected", 32'(exp_d.size() != 0), 1);
      if (exp_d.size() != 0) begin
        chk("m_data", 32'(m_data), 32'(exp_d.pop_front()));
        chk("m_err", 32'(m_err), 32'(exp_e.pop_front()));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic rnd_rdy;

  task automatic tick();
    @(posedge clk); #1;
    if (rnd_rdy) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_cmd(input int len);
    int t = 0;
    cmd_valid = 1'b1; cmd_len = LEN_W'(len);
    while (!cmd_ready && t < 200) begin tick(); t++; end
    chk("cmd_accept_in_time", 32'(t < 200), 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [N-1:0] a, input logic [N-1:0] b);
    int t = 0;
    s_valid = 1'b1; s_a = a; s_b = b;
    while (!s_ready && t < 200) begin tick(); t++; end
    chk("beat_accept_in_time", 32'(t < 200), 1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic stall(input int n);
    s_valid = 1'b0;
    repeat (n) begin
      @(negedge clk); chk("stall_ce", 32'(mac_ce), 0);
      tick();
    end
  endtask

  task automatic run_cmd(input int stall_at, input int stall_n, input bit rnd_stall);
    int len = qa.size();
    model_push(1'b0);
    send_cmd(len);
    for (int i = 0; i < len; i++) begin
      if (i == stall_at) stall(stall_n);
      else if (rnd_stall && $urandom_range(0, 3) == 0) stall($urandom_range(1, 3));
      send_beat(qa[i], qb[i]);
    end
    qa.delete(); qb.delete();
  endtask

  task automatic drain();
    int t = 0;
    while (exp_d.size() != 0 && t < 200) begin tick(); t++; end
    chk("drain_empty", 32'(exp_d.size()), 0);
    tick();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    cmd_valid = 0; cmd_len = '0; s_valid = 0; s_a = '0; s_b = '0;
    m_ready = 1; rnd_rdy = 0; resid = '0;
    arst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_s_ready",   32'(s_ready), 0);
    chk("rst_mac_ce",    32'(mac_ce), 1);
    chk("rst_mac_sload", 32'(mac_sload), 1);
    chk("rst_m_valid",   32'(m_valid), 0);
    chk("rst_m_data",    32'(m_data), 0);
    chk("rst_m_err",     32'(m_err), 0);
    @(posedge clk); #1 arst_n = 1;

    // 1: three 0.5*0.5 products, back-to-back beats, latency k+2
    repeat (3) begin qa.push_back(16'h4000); qb.push_back(16'h4000); end
    run_cmd(-1, 0, 0);
    chk("t1_exp", 32'(exp_d[0]), 32'h3000);
    @(negedge clk); chk("t1_lat_k0", 32'(m_valid), 0);
    tick();
    @(negedge clk); chk("t1_lat_k1", 32'(m_valid), 0);
    tick();
    @(negedge clk); chk("t1_lat_k2", 32'(m_valid), 1);
    drain();

    // 2: extreme operands with a 3-cycle mid-burst stall
    qa = '{16'h7FFF, 16'h0001}; qb = '{16'h8000, 16'h0000};
    run_cmd(1, 3, 0);
    chk("t2_exp", 32'(exp_d[0]), 32'hC000);
    drain();

    // 3: zero-length command
    run_cmd(-1, 0, 0);
    @(negedge clk);
    chk("t3_mv_early", 32'(m_valid), 0);
    chk("t3_sload0",   32'(mac_sload), 1);
    tick();
    @(negedge clk);
    chk("t3_mv",     32'(m_valid), 1);
    chk("t3_sload1", 32'(mac_sload), 1);
    drain();

    // 4: output backpressure while the next result waits in capture
    m_ready = 0;
    qa.push_back(N'($urandom)); qb.push_back(N'($urandom));
    run_cmd(-1, 0, 0);
    qa.push_back(N'($urandom)); qb.push_back(N'($urandom));
    run_cmd(-1, 0, 0);
    tick();
    repeat (5) begin
      @(negedge clk);
      chk("t4_hold_ce",     32'(mac_ce), 0);
      chk("t4_hold_mv",     32'(m_valid), 1);
      chk("t4_hold_data",   32'(m_data), 32'(exp_d[0]));
      chk("t4_hold_cmdrdy", 32'(cmd_ready), 0);
      tick();
    end
    m_ready = 1;
    @(negedge clk); chk("t4_release_ce", 32'(mac_ce), 1);
    tick();
    @(negedge clk);
    chk("t4_next_cmdrdy", 32'(cmd_ready), 1);
    chk("t4_second_mv",   32'(m_valid), 1);
    tick();
    qa.push_back(N'($urandom)); qb.push_back(N'($urandom));
    run_cmd(-1, 0, 0);
    drain();

    // 5: asynchronous reset in the middle of a burst
    send_cmd(3);
    send_beat(16'h1111, 16'h2222);
    s_valid = 1; s_a = 16'h1234; s_b = 16'h5678;
    arst_n = 0;
    #2;
    chk("t5_cmd_ready", 32'(cmd_ready), 1);
    chk("t5_s_ready",   32'(s_ready), 0);
    chk("t5_mac_ce",    32'(mac_ce), 1);
    chk("t5_mac_sload", 32'(mac_sload), 1);
    chk("t5_mac_a",     32'(mac_a), 0);
    chk("t5_mac_b",     32'(mac_b), 0);
    chk("t5_m_valid",   32'(m_valid), 0);
    chk("t5_m_data",    32'(m_data), 0);
    s_valid = 0;
    resid = '0;
    @(posedge clk); #1 arst_n = 1;
    qa = '{16'h2000}; qb = '{16'h4000};
    run_cmd(-1, 0, 0);
    chk("t5_exp", 32'(exp_d[0]), 32'h0800);
    drain();

`ifdef MAC_SEQ_TIMEOUT_EN
    // 6: operands stop after one beat of three; partial sum flagged
    begin
      int t = 0;
      qa = '{16'h4000}; qb = '{16'h4000};
      model_push(1'b1);
      qa.delete(); qb.delete();
      chk("t6_exp", 32'(exp_d[0]), 32'h1000);
      send_cmd(3);
      send_beat(16'h4000, 16'h4000);
      while (!m_valid && t < 50) begin tick(); t++; end
      chk("t6_timeout_in_time", 32'(t < 50), 1);
      chk("t6_s_ready", 32'(s_ready), 0);
      drain();
    end
`endif

    // Random commands with random stalls and random output backpressure
    rnd_rdy = 1;
    for (int c = 0; c < 25; c++) begin
      int len = $urandom_range(0, 6);
      for (int i = 0; i < len; i++) begin
        qa.push_back(N'($urandom)); qb.push_back(N'($urandom));
      end
      run_cmd(-1, 0, 1);
    end
    rnd_rdy = 0; m_ready = 1;
    drain();
    chk("final_m_valid", 32'(m_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
